// File: rtl/layer_three_fc.sv
// rtl/layer_three_fc.sv - binary FC output layer: XNOR-popcount per class, argmax digit, sticky done
// Optional per-class score registers enabled by macro LAYER3_SCORES_EN.
module layer_three_fc #(
   parameter int NUM_CLASSES = 10,
   parameter int IN_BITS     = 196,
   parameter int CHUNK       = 49
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [2:0]                    state,
   input  logic [IN_BITS-1:0]            acts,
   input  logic [NUM_CLASSES*IN_BITS-1:0] weights,
   output logic [3:0]                    digit,
   output logic [NUM_CLASSES*8-1:0]      scores,
   output logic                          done
);

   localparam int NUM_CHUNKS = IN_BITS / CHUNK;
   localparam int MW = $clog2(CHUNK + 1);
   localparam int AW = $clog2(IN_BITS);
   localparam int WW = $clog2(NUM_CLASSES * IN_BITS);
   localparam int SW = $clog2(NUM_CLASSES * 8);
   localparam logic [2:0] S_LAYER_3  = 3'b100;
   localparam logic [3:0] NCLS       = 4'(NUM_CLASSES);
   localparam logic [1:0] CHUNK_LAST = 2'(NUM_CHUNKS - 1);

   logic [3:0] cls_q, cls_d;
   logic [1:0] chunk_q, chunk_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] best_score_q, best_score_d;
   logic [3:0] best_idx_q, best_idx_d;
   logic [3:0] digit_q, digit_d;
   logic       done_q, done_d;

   logic [3:0]       cls_sel;
   logic [AW-1:0]    a_base;
   logic [WW-1:0]    w_base;
   logic [CHUNK-1:0] match;
   logic [MW-1:0]    m;
   logic [7:0]       s;

`ifdef LAYER3_SCORES_EN
   logic [NUM_CLASSES*8-1:0] scores_q, scores_d;
   logic [SW-1:0]            sc_base;
`endif

   // Once cls reaches NUM_CLASSES the datapath is idle; park the select on class 0 to stay in range.
   always_comb begin
      cls_sel = (cls_q != NCLS) ? cls_q : 4'd0;
      a_base  = AW'(chunk_q) * AW'(CHUNK);
      w_base  = WW'(cls_sel) * WW'(IN_BITS) + WW'(chunk_q) * WW'(CHUNK);
      match   = ~(acts[a_base +: CHUNK] ^ weights[w_base +: CHUNK]);
      m = '0;
      for (int i = 0; i < CHUNK; i++) begin
         m = m + MW'(match[i]);
      end
      s = acc_q + 8'(m);
   end

   always_comb begin
      cls_d        = cls_q;
      chunk_d      = chunk_q;
      acc_d        = acc_q;
      best_score_d = best_score_q;
      best_idx_d   = best_idx_q;
      digit_d      = digit_q;
      done_d       = done_q;
`ifdef LAYER3_SCORES_EN
      scores_d = scores_q;
      sc_base  = SW'(cls_sel) * SW'(8);
`endif
      if (state == S_LAYER_3 && !done_q) begin
         if (cls_q != NCLS) begin
            if (chunk_q != CHUNK_LAST) begin
               acc_d   = s;
               chunk_d = chunk_q + 2'd1;
            end else begin
               // Strict compare keeps the lowest class index on ties.
               if (s > best_score_q || cls_q == 4'd0) begin
                  best_score_d = s;
                  best_idx_d   = cls_q;
               end
`ifdef LAYER3_SCORES_EN
               scores_d[sc_base +: 8] = s;
`endif
               acc_d   = 8'd0;
               chunk_d = 2'd0;
               cls_d   = cls_q + 4'd1;
            end
         end else begin
            digit_d = best_idx_q;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cls_q        <= 4'd0;
         chunk_q      <= 2'd0;
         acc_q        <= 8'd0;
         best_score_q <= 8'd0;
         best_idx_q   <= 4'd0;
         digit_q      <= 4'd0;
         done_q       <= 1'b0;
`ifdef LAYER3_SCORES_EN
         scores_q     <= '0;
`endif
      end else begin
         cls_q        <= cls_d;
         chunk_q      <= chunk_d;
         acc_q        <= acc_d;
         best_score_q <= best_score_d;
         best_idx_q   <= best_idx_d;
         digit_q      <= digit_d;
         done_q       <= done_d;
`ifdef LAYER3_SCORES_EN
         scores_q     <= scores_d;
`endif
      end
   end

   assign digit = digit_q;
   assign done  = done_q;
`ifdef LAYER3_SCORES_EN
   assign scores = scores_q;
`else
   assign scores = '0;
`endif

endmodule

// File: tb/tb_layer_three_fc.sv
// tb/tb_layer_three_fc.sv - randomized and directed bench for layer_three_fc against a score/argmax model
// Score checks follow macro LAYER3_SCORES_EN.
module tb_layer_three_fc;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    state;
   logic [195:0]  acts;
   logic [1959:0] weights;
   logic [3:0]    digit;
   logic [79:0]   scores;
   logic          done;

   int nvec  = 0;
   int nfail = 0;
   int q     = 0;
   bit chk_en = 1'b0;
   logic [7:0] ref_score [10];
   logic [3:0] ref_best;

   layer_three_fc dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .state   (state),
      .acts    (acts),
      .weights (weights),
      .digit   (digit),
      .scores  (scores),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Model time base: number of qualifying edges since reset, saturating at 41.
   always @(posedge clk) begin
      if (!rst_n)                         q <= 0;
      else if (state == 3'b100 && q < 41) q <= q + 1;
   end

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [79:0] exp_scores();
      logic [79:0] r = '0;
`ifdef LAYER3_SCORES_EN
      for (int c = 0; c < 10; c++)
         if (q >= 4 * (c + 1)) r[c*8 +: 8] = ref_score[c];
`endif
      return r;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("done",   80'(done),   80'(q >= 41));
         chk("digit",  80'(digit),  (q >= 41) ? 80'(ref_best) : 80'd0);
         chk("scores", scores,      exp_scores());
      end
   end

   task automatic compute_ref();
      ref_best = 4'd0;
      for (int c = 0; c < 10; c++) begin
         ref_score[c] = 8'($countones(~(acts ^ weights[c*196 +: 196])));
         if (ref_score[c] > ref_score[ref_best]) ref_best = 4'(c);
      end
   endtask

   task automatic edges(input int n, input logic [2:0] st);
      state = st;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      edges(1, 3'b000);
      rst_n = 1'b1;
   endtask

   task automatic rand_load();
      logic [223:0]  a;
      logic [1983:0] w;
      int j;
      for (int i = 0; i < 7; i++)  a[i*32 +: 32] = $urandom;
      for (int i = 0; i < 62; i++) w[i*32 +: 32] = $urandom;
      acts    = a[195:0];
      weights = w[1959:0];
      if ($urandom_range(0, 2) == 0) begin
         j = $urandom_range(1, 9);
         weights[j*196 +: 196] = weights[0 +: 196];
      end
      if ($urandom_range(0, 3) == 0) begin
         j = $urandom_range(0, 9);
         weights[j*196 +: 196] = acts;
      end
      compute_ref();
   endtask

   initial begin
      int guard;
      logic [2:0] st;
      rst_n   = 1'b0;
      state   = 3'b000;
      acts    = '0;
      weights = '0;
      do_reset();
      chk_en = 1'b1;
      chk("reset_done",   80'(done),  80'd0);
      chk("reset_digit",  80'(digit), 80'd0);
      chk("reset_scores", scores,     80'd0);

      // 1: only class 7 matches zero activations
      weights = '1;
      weights[7*196 +: 196] = '0;
      compute_ref();
      chk("t1_model", 80'(ref_best), 80'd7);
      edges(40, 3'b100);
      chk("t1_not_before", 80'(done), 80'd0);
      edges(1, 3'b100);
      chk("t1_done",  80'(done),  80'd1);
      chk("t1_digit", 80'(digit), 80'd7);

      // 6: weights changed after done must not disturb the result
      weights[5*196 +: 196] = '0;
      weights[7*196 +: 196] = '1;
      edges(10, 3'b100);
      chk("t6_digit", 80'(digit), 80'd7);
      chk("t6_done",  80'(done),  80'd1);

      // 2: all scores 196, tie resolves to class 0
      do_reset();
      acts = '0;
      weights = '0;
      compute_ref();
      edges(41, 3'b100);
      chk("t2_digit", 80'(digit), 80'd0);
`ifdef LAYER3_SCORES_EN
      chk("t2_scores", scores, {10{8'hC4}});
`else
      chk("t2_scores", scores, 80'd0);
`endif

      // 3: class 3 matches only on plane 2
      do_reset();
      acts = '1;
      weights = '0;
      weights[3*196 + 98 +: 49] = '1;
      compute_ref();
      chk("t3_model", 80'(ref_score[3]), 80'd49);
      edges(41, 3'b100);
      chk("t3_digit", 80'(digit), 80'd3);
`ifdef LAYER3_SCORES_EN
      chk("t3_score3", 80'(scores[3*8 +: 8]), 80'd49);
`endif

      // 4: pause for 10 edges mid-run
      do_reset();
      acts = '0;
      weights = '1;
      weights[7*196 +: 196] = '0;
      compute_ref();
      edges(20, 3'b100);
      edges(10, 3'b011);
      edges(20, 3'b100);
      chk("t4_not_before", 80'(done), 80'd0);
      edges(1, 3'b100);
      chk("t4_done",  80'(done),  80'd1);
      chk("t4_digit", 80'(digit), 80'd7);

      // 5: reset on edge 25 then full rerun
      do_reset();
      edges(24, 3'b100);
      rst_n = 1'b0;
      edges(1, 3'b100);
      rst_n = 1'b1;
      chk("t5_rst_done",  80'(done),  80'd0);
      chk("t5_rst_digit", 80'(digit), 80'd0);
      edges(40, 3'b100);
      chk("t5_not_before", 80'(done), 80'd0);
      edges(1, 3'b100);
      chk("t5_digit", 80'(digit), 80'd7);

      // Randomized runs with random pauses
      for (int r = 0; r < 10; r++) begin
         do_reset();
         rand_load();
         guard = 0;
         while (q < 41 && guard < 400) begin
            st = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'b100;
            edges(1, st);
            guard++;
         end
         if (q < 41) begin
            nvec++;
            nfail++;
            $display("FAIL rand_timeout: run %0d reached %0d of 41 edges", r, q);
         end
         edges(3, 3'b100);
         chk("rand_digit", 80'(digit), 80'(ref_best));
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
